sdram_port_arbiter: RTL and testbench

- Shares one SDRAM controller port between NUM_CLIENTS requesters using round-robin arbitration.
- Buffers one request per client, issues it downstream, and routes the response back to the issuing client.
- Sits between video, audio and CPU-bus clients and one port of the multi-port SDRAM wrapper.
- Only one downstream transaction is outstanding at a time.

---
 rtl/sdram_arb_pkg.sv | 28 ++
 rtl/rr_arbiter.sv | 25 ++
 rtl/sdram_port_arbiter.sv | 168 ++++++++++++++++
 tb/tb_sdram_port_arbiter.sv | 361 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sdram_arb_pkg.sv
// Shared types and the round-robin grant function for the SDRAM port arbiter.
package sdram_arb_pkg;

  localparam int unsigned MaxClients = 8;

  typedef enum logic [1:0] {StIdle, StIssue, StWait} state_e;
  typedef enum logic {OpRd, OpWr} op_e;

  // First pending index after last_grant, wrapping at num_clients-1 -> 0.
  function automatic logic [2:0] rr_next(input logic [7:0]  pending,
                                         input logic [2:0]  last_grant,
                                         input int unsigned num_clients);
    logic [2:0]  grant;
    logic        found;
    int unsigned idx;
    grant = '0;
    found = 1'b0;
    for (int unsigned k = 1; k <= MaxClients; k++) begin
      idx = (32'(last_grant) + k) % num_clients;
      if (!found && k <= num_clients && pending[idx[2:0]]) begin
        grant = idx[2:0];
        found = 1'b1;
      end
    end
    return grant;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin priority picker over the pending request slots.
module rr_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int unsigned NUM_CLIENTS = 4,
  parameter int unsigned IDX_W       = $clog2(NUM_CLIENTS)
) (
  input  logic [NUM_CLIENTS-1:0] pending,
  input  logic [IDX_W-1:0]       last_grant,
  output logic                   valid,
  output logic [IDX_W-1:0]       grant
);

  logic [MaxClients-1:0] pend_ext;
  logic [2:0]            pick;

  always_comb begin
    pend_ext                  = '0;
    pend_ext[NUM_CLIENTS-1:0] = pending;
    pick                      = rr_next(pend_ext, 3'(last_grant), NUM_CLIENTS);
    grant                     = pick[IDX_W-1:0];
    valid                     = |pending;
  end

endmodule

// File: rtl/sdram_port_arbiter.sv
// Shares one SDRAM controller port between NUM_CLIENTS requesters, one slot per client,
// round-robin grant, a single outstanding downstream transaction.
module sdram_port_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int unsigned NUM_CLIENTS  = 4,
  parameter int unsigned ADDR_WIDTH   = 25,
  parameter int unsigned DATA_WIDTH   = 16,
  parameter int unsigned DQM_WIDTH    = 2,
  parameter int unsigned OUTPUT_WIDTH = 16
) (
  input  logic                              clk,
  input  logic                              reset_n,
  input  logic [NUM_CLIENTS*ADDR_WIDTH-1:0] c_addr,
  input  logic [NUM_CLIENTS*DATA_WIDTH-1:0] c_data,
  input  logic [NUM_CLIENTS*DQM_WIDTH-1:0]  c_byte_en,
  input  logic [NUM_CLIENTS-1:0]            c_rd,
  input  logic [NUM_CLIENTS-1:0]            c_wr,
  output logic [NUM_CLIENTS-1:0]            c_available,
  output logic [NUM_CLIENTS-1:0]            c_ready,
  output logic [NUM_CLIENTS*OUTPUT_WIDTH-1:0] c_q,
  output logic [ADDR_WIDTH-1:0]             dn_addr,
  output logic [DATA_WIDTH-1:0]             dn_data,
  output logic [DQM_WIDTH-1:0]              dn_byte_en,
  output logic                              dn_rd,
  output logic                              dn_wr,
  input  logic [OUTPUT_WIDTH-1:0]           dn_q,
  input  logic                              dn_available,
  input  logic                              dn_ready
);

  localparam int unsigned IDX_W = $clog2(NUM_CLIENTS);

  logic [ADDR_WIDTH-1:0] slot_addr_q [NUM_CLIENTS];
  logic [DATA_WIDTH-1:0] slot_data_q [NUM_CLIENTS];
  logic [DQM_WIDTH-1:0]  slot_be_q   [NUM_CLIENTS];
  op_e                   slot_op_q   [NUM_CLIENTS];

  logic [NUM_CLIENTS-1:0] pending_q, pending_d, accept;
  logic [NUM_CLIENTS-1:0] c_available_q;
  logic [NUM_CLIENTS-1:0] c_ready_q, c_ready_d;
  logic [NUM_CLIENTS*OUTPUT_WIDTH-1:0] c_q_q, c_q_d;
  logic [ADDR_WIDTH-1:0]  dn_addr_q, dn_addr_d;
  logic [DATA_WIDTH-1:0]  dn_data_q, dn_data_d;
  logic [DQM_WIDTH-1:0]   dn_be_q, dn_be_d;
  logic                   dn_rd_q, dn_rd_d, dn_wr_q, dn_wr_d;
  state_e                 state_q, state_d;
  logic [IDX_W-1:0]       grant_q, grant_d, last_grant_q, last_grant_d;
  logic                   arb_valid;
  logic [IDX_W-1:0]       arb_grant;

  assign accept = c_available_q & (c_rd | c_wr);

  rr_arbiter #(
    .NUM_CLIENTS (NUM_CLIENTS),
    .IDX_W       (IDX_W)
  ) u_rr_arbiter (
    .pending    (pending_q),
    .last_grant (last_grant_q),
    .valid      (arb_valid),
    .grant      (arb_grant)
  );

  // Write wins when a client strobes rd and wr together.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < int'(NUM_CLIENTS); i++) begin
        slot_addr_q[i] <= '0;
        slot_data_q[i] <= '0;
        slot_be_q[i]   <= '0;
        slot_op_q[i]   <= OpRd;
      end
    end else begin
      for (int i = 0; i < int'(NUM_CLIENTS); i++) begin
        if (accept[i]) begin
          slot_addr_q[i] <= c_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
          slot_data_q[i] <= c_data[i*DATA_WIDTH +: DATA_WIDTH];
          slot_be_q[i]   <= c_byte_en[i*DQM_WIDTH +: DQM_WIDTH];
          slot_op_q[i]   <= c_wr[i] ? OpWr : OpRd;
        end
      end
    end
  end

  always_comb begin
    pending_d    = pending_q | accept;
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    dn_addr_d    = dn_addr_q;
    dn_data_d    = dn_data_q;
    dn_be_d      = dn_be_q;
    dn_rd_d      = 1'b0;
    dn_wr_d      = 1'b0;
    c_ready_d    = '0;
    c_q_d        = c_q_q;
    case (state_q)
      StIdle: begin
        if (arb_valid) begin
          grant_d      = arb_grant;
          last_grant_d = arb_grant;
          dn_addr_d    = slot_addr_q[arb_grant];
          dn_data_d    = slot_data_q[arb_grant];
          dn_be_d      = slot_be_q[arb_grant];
          state_d      = StIssue;
        end
      end
      StIssue: begin
        if (dn_available) begin
          if (slot_op_q[grant_q] == OpWr) dn_wr_d = 1'b1;
          else                            dn_rd_d = 1'b1;
          state_d = StWait;
        end
      end
      StWait: begin
        if (dn_ready) begin
          pending_d[grant_q] = 1'b0;
          c_ready_d[grant_q] = 1'b1;
          if (slot_op_q[grant_q] == OpRd) begin
            c_q_d[32'(grant_q)*OUTPUT_WIDTH +: OUTPUT_WIDTH] = dn_q;
          end
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= StIdle;
      pending_q     <= '0;
      c_available_q <= '1;
      c_ready_q     <= '0;
      c_q_q         <= '0;
      grant_q       <= '0;
      last_grant_q  <= IDX_W'(NUM_CLIENTS - 1);
      dn_addr_q     <= '0;
      dn_data_q     <= '0;
      dn_be_q       <= '0;
      dn_rd_q       <= 1'b0;
      dn_wr_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      pending_q     <= pending_d;
      c_available_q <= ~pending_d;
      c_ready_q     <= c_ready_d;
      c_q_q         <= c_q_d;
      grant_q       <= grant_d;
      last_grant_q  <= last_grant_d;
      dn_addr_q     <= dn_addr_d;
      dn_data_q     <= dn_data_d;
      dn_be_q       <= dn_be_d;
      dn_rd_q       <= dn_rd_d;
      dn_wr_q       <= dn_wr_d;
    end
  end

  assign c_available = c_available_q;
  assign c_ready     = c_ready_q;
  assign c_q         = c_q_q;
  assign dn_addr     = dn_addr_q;
  assign dn_data     = dn_data_q;
  assign dn_byte_en  = dn_be_q;
  assign dn_rd       = dn_rd_q;
  assign dn_wr       = dn_wr_q;

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Directed bench for sdram_port_arbiter with a simple fixed-latency controller model.
module tb_sdram_port_arbiter;

  localparam int N  = 4;
  localparam int AW = 25;
  localparam int DW = 16;
  localparam int BW = 2;
  localparam int OW = 16;
  localparam logic [15:0] SALT = 16'hACDB;

  logic              clk = 1'b0;
  logic              reset_n;
  logic [N*AW-1:0]   c_addr;
  logic [N*DW-1:0]   c_data;
  logic [N*BW-1:0]   c_byte_en;
  logic [N-1:0]      c_rd, c_wr, c_available, c_ready;
  logic [N*OW-1:0]   c_q;
  logic [AW-1:0]     dn_addr;
  logic [DW-1:0]     dn_data;
  logic [BW-1:0]     dn_byte_en;
  logic              dn_rd, dn_wr, dn_available, dn_ready;
  logic [OW-1:0]     dn_q;

  logic              model_ready = 1'b0;
  logic              force_ready = 1'b0;
  int                lat = 4;
  int                cnt = 0;
  logic [AW-1:0]     rsp_addr = '0;
  logic [AW-1:0]     log_addr[$];
  logic [DW-1:0]     log_data[$];
  logic [BW-1:0]     log_be[$];
  logic              log_wr[$];
  int                ready_cnt[N];

  int vectors = 0;
  int miscompares = 0;

  assign dn_ready = model_ready | force_ready;

  always #5 clk = ~clk;

  sdram_port_arbiter dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .c_addr       (c_addr),
    .c_data       (c_data),
    .c_byte_en    (c_byte_en),
    .c_rd         (c_rd),
    .c_wr         (c_wr),
    .c_available  (c_available),
    .c_ready      (c_ready),
    .c_q          (c_q),
    .dn_addr      (dn_addr),
    .dn_data      (dn_data),
    .dn_byte_en   (dn_byte_en),
    .dn_rd        (dn_rd),
    .dn_wr        (dn_wr),
    .dn_q         (dn_q),
    .dn_available (dn_available),
    .dn_ready     (dn_ready)
  );

  // Controller model: logs each strobe, answers lat cycles later with addr ^ SALT.
  initial dn_q = '0;
  always @(posedge clk) begin
    model_ready <= 1'b0;
    if (cnt > 0) begin
      cnt <= cnt - 1;
      if (cnt == 1) begin
        model_ready <= 1'b1;
        dn_q        <= rsp_addr[15:0] ^ SALT;
      end
    end
    if (dn_rd || dn_wr) begin
      log_addr.push_back(dn_addr);
      log_data.push_back(dn_data);
      log_be.push_back(dn_byte_en);
      log_wr.push_back(dn_wr);
      rsp_addr <= dn_addr;
      cnt      <= lat;
    end
  end

  always @(posedge clk) begin
    for (int i = 0; i < N; i++) if (c_ready[i]) ready_cnt[i] <= ready_cnt[i] + 1;
  end

  task automatic strobe(input int idx, input logic rd, input logic wr, input logic [AW-1:0] a,
                        input logic [DW-1:0] d, input logic [BW-1:0] be);
    @(negedge clk);
    c_addr[idx*AW +: AW]  = a;
    c_data[idx*DW +: DW]  = d;
    c_byte_en[idx*BW +: BW] = be;
    c_rd[idx] = rd;
    c_wr[idx] = wr;
    @(negedge clk);
    c_rd[idx] = 1'b0;
    c_wr[idx] = 1'b0;
  endtask

  task automatic wait_ready(input int idx, input int target, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (ready_cnt[idx] >= target) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    vectors++;
    if (c_available !== 4'hF) begin
      miscompares++; $display("FAIL reset_avail: got %h want f", c_available);
    end
    vectors++;
    if ({dn_rd, dn_wr, c_ready} !== 6'b0) begin
      miscompares++; $display("FAIL reset_strobes: got %b want 000000", {dn_rd, dn_wr, c_ready});
    end
    vectors++;
    if (c_q !== '0 || dn_addr !== '0) begin
      miscompares++; $display("FAIL reset_data: got c_q %h dn_addr %h want 0", c_q, dn_addr);
    end
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single_read();
    int base = log_addr.size();
    int r0 = ready_cnt[2];
    bit ok;
    lat = 4;
    strobe(2, 1'b1, 1'b0, 25'h0001234, 16'h0, 2'b11);
    vectors++;
    if (c_available[2] !== 1'b0) begin
      miscompares++; $display("FAIL rd_avail_low: got %b want 0", c_available[2]);
    end
    repeat (2) @(negedge clk);
    vectors++;
    if ({dn_rd, dn_wr, dn_addr} !== {2'b10, 25'h0001234}) begin
      miscompares++;
      $display("FAIL rd_issue: got rd %b wr %b addr %h want 1 0 0001234", dn_rd, dn_wr, dn_addr);
    end
    wait_ready(2, r0 + 1, ok);
    repeat (3) @(negedge clk);
    vectors++;
    if (!ok || ready_cnt[2] !== r0 + 1) begin
      miscompares++; $display("FAIL rd_ready: got %0d pulses want %0d", ready_cnt[2] - r0, 1);
    end
    vectors++;
    if (c_q[2*OW +: OW] !== 16'hBEEF) begin
      miscompares++; $display("FAIL rd_data: got %h want beef", c_q[2*OW +: OW]);
    end
    vectors++;
    if (log_addr.size() !== base + 1) begin
      miscompares++; $display("FAIL rd_count: got %0d strobes want 1", log_addr.size() - base);
    end else if (log_wr[base] !== 1'b0) begin
      vectors++; miscompares++; $display("FAIL rd_op: got wr want rd");
    end
    vectors++;
    if (c_available !== 4'hF) begin
      miscompares++; $display("FAIL rd_avail_back: got %h want f", c_available);
    end
  endtask

  task automatic test_spurious_ready();
    int r1 = ready_cnt[1];
    int base = log_addr.size();
    bit ok;
    @(negedge clk);
    force_ready = 1'b1;
    @(negedge clk);
    force_ready = 1'b0;
    repeat (2) @(negedge clk);
    vectors++;
    if (c_ready !== '0 || ready_cnt[0] + ready_cnt[1] + ready_cnt[3] !== r1) begin
      miscompares++; $display("FAIL spur_ready: got c_ready %b want 0000", c_ready);
    end
    lat = 2;
    strobe(1, 1'b1, 1'b0, 25'h0000042, 16'h0, 2'b11);
    repeat (2) @(negedge clk);
    vectors++;
    if (dn_rd !== 1'b1 || dn_addr !== 25'h0000042) begin
      miscompares++; $display("FAIL spur_issue: got rd %b addr %h want 1 0000042", dn_rd, dn_addr);
    end
    wait_ready(1, r1 + 1, ok);
    vectors++;
    if (!ok || c_q[1*OW +: OW] !== (16'h0042 ^ SALT)) begin
      miscompares++; $display("FAIL spur_data: got %h want %h", c_q[OW +: OW], 16'h0042 ^ SALT);
    end
    vectors++;
    if (log_addr.size() !== base + 1) begin
      miscompares++; $display("FAIL spur_count: got %0d want 1", log_addr.size() - base);
    end
  endtask

  task automatic test_round_robin();
    logic [AW-1:0] exp_order[4];
    int base;
    int r0;
    bit ok, ok2;
    exp_order[0] = 25'h100; exp_order[1] = 25'h101;
    exp_order[2] = 25'h103; exp_order[3] = 25'h100;
    do_reset();
    base = log_addr.size();
    r0 = ready_cnt[0];
    lat = 2;
    @(negedge clk);
    c_addr[0*AW +: AW] = 25'h100; c_addr[1*AW +: AW] = 25'h101; c_addr[3*AW +: AW] = 25'h103;
    c_rd = 4'b1011;
    @(negedge clk);
    c_rd = 4'b0000;
    wait_ready(0, r0 + 1, ok);
    strobe(0, 1'b1, 1'b0, 25'h100, 16'h0, 2'b11);
    wait_ready(0, r0 + 2, ok2);
    repeat (2) @(negedge clk);
    vectors++;
    if (!ok || !ok2 || log_addr.size() !== base + 4) begin
      miscompares++; $display("FAIL rr_count: got %0d strobes want 4", log_addr.size() - base);
    end else begin
      for (int k = 0; k < 4; k++) begin
        vectors++;
        if (log_addr[base + k] !== exp_order[k]) begin
          miscompares++;
          $display("FAIL rr_order[%0d]: got %h want %h", k, log_addr[base + k], exp_order[k]);
        end
      end
    end
    vectors++;
    if (c_q[3*OW +: OW] !== (16'h0103 ^ SALT)) begin
      miscompares++; $display("FAIL rr_data3: got %h want %h", c_q[3*OW +: OW], 16'h0103 ^ SALT);
    end
  endtask

  task automatic test_backpressure();
    int base = log_addr.size();
    int r1 = ready_cnt[1];
    bit ok;
    dn_available = 1'b0;
    strobe(1, 1'b0, 1'b1, 25'h200, 16'h55AA, 2'b01);
    repeat (10) @(negedge clk);
    vectors++;
    if (log_addr.size() !== base || dn_wr !== 1'b0) begin
      miscompares++; $display("FAIL bp_stall: got %0d strobes want 0", log_addr.size() - base);
    end
    vectors++;
    if (c_available[1] !== 1'b0) begin
      miscompares++; $display("FAIL bp_avail: got %b want 0", c_available[1]);
    end
    dn_available = 1'b1;
    wait_ready(1, r1 + 1, ok);
    vectors++;
    if (!ok || log_addr.size() !== base + 1) begin
      miscompares++; $display("FAIL bp_count: got %0d strobes want 1", log_addr.size() - base);
    end else begin
      vectors++;
      if ({log_wr[base], log_data[base], log_be[base]} !== {1'b1, 16'h55AA, 2'b01}) begin
        miscompares++;
        $display("FAIL bp_write: got wr %b data %h be %b want 1 55aa 01",
                 log_wr[base], log_data[base], log_be[base]);
      end
    end
  endtask

  task automatic test_rd_wr_both();
    int base = log_addr.size();
    int r0 = ready_cnt[0];
    bit ok;
    strobe(0, 1'b1, 1'b1, 25'h300, 16'h1357, 2'b11);
    wait_ready(0, r0 + 1, ok);
    vectors++;
    if (!ok || log_addr.size() !== base + 1 || log_wr[base] !== 1'b1) begin
      miscompares++; $display("FAIL both_op: got %0d strobes want one write", log_addr.size() - base);
    end
    vectors++;
    if (c_q[0 +: OW] !== (16'h0100 ^ SALT)) begin
      miscompares++; $display("FAIL both_cq_hold: got %h want %h", c_q[0 +: OW], 16'h0100 ^ SALT);
    end
  endtask

  task automatic test_ignored_strobe();
    int base = log_addr.size();
    int r3 = ready_cnt[3];
    bit ok;
    lat = 6;
    strobe(3, 1'b1, 1'b0, 25'h400, 16'h0, 2'b11);
    strobe(3, 1'b0, 1'b1, 25'h401, 16'h9999, 2'b11);
    wait_ready(3, r3 + 1, ok);
    repeat (12) @(negedge clk);
    vectors++;
    if (!ok || log_addr.size() !== base + 1 || ready_cnt[3] !== r3 + 1) begin
      miscompares++;
      $display("FAIL ign_count: got %0d strobes %0d readies want 1 1",
               log_addr.size() - base, ready_cnt[3] - r3);
    end else begin
      vectors++;
      if (log_addr[base] !== 25'h400 || log_wr[base] !== 1'b0) begin
        miscompares++; $display("FAIL ign_slot: got addr %h want 0000400 rd", log_addr[base]);
      end
    end
  endtask

  task automatic test_reset_mid();
    int base;
    int r2 = ready_cnt[2];
    lat = 8;
    strobe(2, 1'b1, 1'b0, 25'h500, 16'h0, 2'b11);
    repeat (3) @(negedge clk);
    base = log_addr.size();
    reset_n = 1'b0;
    @(negedge clk);
    vectors++;
    if ({c_available, dn_rd, dn_wr, c_ready} !== {4'hF, 6'b0}) begin
      miscompares++;
      $display("FAIL mid_reset: got avail %h rd %b wr %b ready %b want f 0 0 0000",
               c_available, dn_rd, dn_wr, c_ready);
    end
    @(negedge clk);
    reset_n = 1'b1;
    repeat (15) @(negedge clk);
    vectors++;
    if (ready_cnt[2] !== r2 || c_q[2*OW +: OW] !== 16'h0) begin
      miscompares++;
      $display("FAIL mid_late_ready: got %0d readies c_q %h want 0 0000",
               ready_cnt[2] - r2, c_q[2*OW +: OW]);
    end
    vectors++;
    if (log_addr.size() !== base || c_available !== 4'hF) begin
      miscompares++;
      $display("FAIL mid_dropped: got %0d new strobes avail %h want 0 f",
               log_addr.size() - base, c_available);
    end
  endtask

  initial begin
    for (int i = 0; i < N; i++) ready_cnt[i] = 0;
    c_addr = '0; c_data = '0; c_byte_en = '0; c_rd = '0; c_wr = '0;
    dn_available = 1'b1;
    test_reset();
    test_single_read();
    test_spurious_ready();
    test_round_robin();
    test_backpressure();
    test_rd_wr_both();
    test_ignored_strobe();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
